// File: rtl/int_div_rem_pkg.sv
// Shared types and message layout for the iterative integer divider.
package int_div_rem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_LSB  = 0;
  localparam int REMAINDER_LSB = 0;

  function automatic int divisor_lsb(input int nbits);
    return nbits;
  endfunction

  function automatic int signed_bit(input int nbits);
    return 2 * nbits;
  endfunction

  function automatic int quotient_lsb(input int nbits);
    return nbits;
  endfunction

  // Radix must be 2, 4 or 16 and divide an even operand width of at least 8 bits
  function automatic bit cfg_legal(input int nbits, input int iter_bits);
    return ((iter_bits == 1) || (iter_bits == 2) || (iter_bits == 4)) &&
           (nbits % iter_bits == 0) && (nbits >= 8) && (nbits % 2 == 0);
  endfunction

endpackage

// File: rtl/int_div_rem_step.sv
// One restoring radix-2^ITER_BITS division step on unsigned magnitudes.
module int_div_rem_step #(
  parameter int NBITS     = 64,
  parameter int ITER_BITS = 2
) (
  input  logic [NBITS-1:0]     rem_in,
  input  logic [ITER_BITS-1:0] bits_in,
  input  logic [NBITS-1:0]     divisor,
  output logic [NBITS-1:0]     rem_out,
  output logic [ITER_BITS-1:0] q_bits
);

  logic [NBITS:0] trial;

  // The partial remainder is always below the divisor, so one extra bit suffices
  always_comb begin
    trial  = {1'b0, rem_in};
    q_bits = '0;
    for (int i = ITER_BITS - 1; i >= 0; i--) begin
      trial = {trial[NBITS-1:0], bits_in[i]};
      if (trial >= {1'b0, divisor}) begin
        q_bits[i] = 1'b1;
        trial     = trial - {1'b0, divisor};
      end
    end
    rem_out = trial[NBITS-1:0];
  end

endmodule

// File: rtl/int_div_rem_n.sv
// Iterative signed/unsigned divider with val/rdy request and response channels.
// Optional build macro INT_DIV_REM_EARLY_EXIT_EN skips iteration for trivial quotients.
module int_div_rem_n
  import int_div_rem_pkg::*;
#(
  parameter int NBITS     = 64,
  parameter int ITER_BITS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*NBITS:0]   req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [2*NBITS-1:0] resp_msg,
  output logic               resp_dbz
);

  localparam int STEPS   = NBITS / ITER_BITS;
  localparam int CNT_W   = $clog2(STEPS + 1);
  localparam int DVS_LSB = divisor_lsb(NBITS);
  localparam int SGN_BIT = signed_bit(NBITS);
  localparam int QUO_LSB = quotient_lsb(NBITS);
  localparam bit CFG_OK  = cfg_legal(NBITS, ITER_BITS);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("int_div_rem_n: illegal NBITS/ITER_BITS combination");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [NBITS-1:0]   rem_q, quo_q, dvs_q;
  logic               neg_q, neg_r, dbz_q;

  logic               accept, early;
  logic               in_signed, in_dvd_neg, in_dvs_neg, in_dvs_zero;
  logic [NBITS-1:0]   in_dvd, in_dvs, in_dvd_mag, in_dvs_mag;
  logic [NBITS-1:0]   step_rem, nxt_quo;
  logic [ITER_BITS-1:0] step_q;
  logic [2*NBITS-1:0] fin_msg, early_msg;

  assign accept      = req_val && req_rdy;
  assign in_dvd      = req_msg[DIVIDEND_LSB +: NBITS];
  assign in_dvs      = req_msg[DVS_LSB +: NBITS];
  assign in_signed   = req_msg[SGN_BIT];
  assign in_dvd_neg  = in_signed && in_dvd[NBITS-1];
  assign in_dvs_neg  = in_signed && in_dvs[NBITS-1];
  assign in_dvs_zero = (in_dvs == '0);
  assign in_dvd_mag  = in_dvd_neg ? -in_dvd : in_dvd;
  assign in_dvs_mag  = in_dvs_neg ? -in_dvs : in_dvs;

`ifdef INT_DIV_REM_EARLY_EXIT_EN
  assign early = in_dvs_zero || (in_dvd_mag < in_dvs_mag);
`else
  assign early = 1'b0;
`endif

  int_div_rem_step #(
    .NBITS    (NBITS),
    .ITER_BITS(ITER_BITS)
  ) u_step (
    .rem_in (rem_q),
    .bits_in(quo_q[NBITS-1 -: ITER_BITS]),
    .divisor(dvs_q),
    .rem_out(step_rem),
    .q_bits (step_q)
  );

  // Dividend bits leave the top of quo_q as quotient bits enter at the bottom
  assign nxt_quo = {quo_q[NBITS-ITER_BITS-1:0], step_q};

  always_comb begin
    fin_msg = '0;
    fin_msg[QUO_LSB +: NBITS]       = dbz_q ? {NBITS{1'b1}} : (neg_q ? -nxt_quo : nxt_quo);
    fin_msg[REMAINDER_LSB +: NBITS] = neg_r ? -step_rem : step_rem;
  end

  always_comb begin
    early_msg = '0;
    early_msg[QUO_LSB +: NBITS]       = {NBITS{in_dvs_zero}};
    early_msg[REMAINDER_LSB +: NBITS] = in_dvd;
  end

  // Operand and iteration registers carry no reset; they are reloaded on every accept
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q <= '0;
      quo_q <= in_dvd_mag;
      dvs_q <= in_dvs_mag;
      neg_q <= in_dvd_neg ^ in_dvs_neg;
      neg_r <= in_dvd_neg;
      dbz_q <= in_dvs_zero;
    end else if (state == CALC) begin
      rem_q <= step_rem;
      quo_q <= nxt_quo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
      resp_dbz <= 1'b0;
      resp_msg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_rdy <= 1'b0;
            if (early) begin
              state    <= DONE;
              resp_val <= 1'b1;
              resp_msg <= early_msg;
              resp_dbz <= in_dvs_zero;
            end else begin
              state <= CALC;
              cnt   <= CNT_W'(STEPS);
            end
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            resp_val <= 1'b1;
            resp_msg <= fin_msg;
            resp_dbz <= dbz_q;
          end
        end
        DONE: begin
          if (resp_rdy) begin
            state    <= IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
        end
      endcase
    end
  end

endmodule
